// File: rtl/mul_seq_ctrl_if.sv
// Start/done handshake and operand/result bus between the control unit and
// the multi-cycle MUL unit.
interface mul_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             ovf;
  logic             zero;

  // Requester side: issues operands and start, observes status and result.
  modport master (
    output start,
    output op_a,
    output op_b,
    input  ready,
    input  busy,
    input  done,
    input  product,
    input  ovf,
    input  zero
  );

  // Multiplier side.
  modport slave (
    input  start,
    input  op_a,
    input  op_b,
    output ready,
    output busy,
    output done,
    output product,
    output ovf,
    output zero
  );

endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequential multiplier by repeated addition: product = op_a * op_b mod 2^WIDTH.
// A is added into P once per cycle while B counts down to zero.
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_ILLEGAL = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum_c;
  logic             beq_c;

  // Accumulator adder with carry-out and zero detector on the iteration count.
  assign sum_c = {1'b0, p_q} + {1'b0, a_q};
  assign beq_c = (b_q == '0);

  // State and datapath registers; reset wins over everything, including S_RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; status flags are decoded from the next state
  // so they can be registered without adding a cycle of latency.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          p_d     = '0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (beq_c) begin
          state_d = S_DONE;
        end else begin
          // Decrement only while B is non-zero, so it never wraps.
          p_d   = sum_c[WIDTH-1:0];
          ovf_d = ovf_q | sum_c[WIDTH];
          b_d   = b_q - WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        // Unreachable encoding: recover to idle without touching the datapath.
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN) || (state_d == S_DONE);
    done_d  = (state_d == S_DONE);
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = p_q;
  assign bus.ovf     = ovf_q;
  // Zero flag is decoded straight from the product register.
  assign bus.zero    = (p_q == '0);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: expected results are queued when a
// multiply is issued and compared when the DUT pulses done.
module tb_mul_seq_ctrl;

  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic             ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int          n_total;
  int          n_bad;
  exp_t        sb[$];

  mul_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Count one comparison and report it if it misses.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width product; overflow iff the true product needs more than WIDTH bits.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [63:0] full;
    exp_t        e;
    full  = 64'(a) * 64'(b);
    e.p   = full[WIDTH-1:0];
    e.ovf = (full[63:WIDTH] != '0);
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", 64'(bus.product), 64'(e.p));
        chk("ovf", 64'(bus.ovf), 64'(e.ovf));
        chk("zero", 64'(bus.zero), 64'(e.p == '0));
      end
    end
  end

  // Wait for ready with a cycle budget.
  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.ready) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  // Count edges from the accept edge until done is seen; compare to expected latency.
  task automatic wait_done(input int unsigned exp_lat, input string tag);
    int unsigned k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!bus.done && k < 300);
    chk(tag, 64'(k), 64'(exp_lat));
  endtask

  // Issue one multiply, check latency, single-cycle done and return to ready.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input string tag, output int unsigned acc_cyc);
    wait_ready();
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    acc_cyc   = cyc;
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    wait_done(b + 1, {tag, "_lat"});
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
    chk({tag, "_ready_back"}, 64'(bus.ready), 64'd1);
  endtask

  initial begin
    int unsigned acc1, acc2;
    logic        seen_done;

    n_total   = 0;
    n_bad     = 0;
    cyc       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_product", 64'(bus.product), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd1);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);

    // Basic multiply and the zero-iteration / zero-addend corners.
    run_mul(32'd7, 32'd5, "t1", acc1);
    run_mul(32'd123, 32'd0, "t2a", acc1);
    run_mul(32'd0, 32'd4, "t2b", acc1);

    // Overflow is sticky within a run and cleared at the next accept.
    run_mul(32'h8000_0000, 32'd3, "t3a", acc1);
    run_mul(32'd2, 32'd2, "t3b", acc1);
    run_mul(32'hFFFF_FFFF, 32'd2, "t3c", acc1);

    // Start held high; operands changed mid-run must not disturb the latched run.
    wait_ready();
    bus.start = 1'b1;
    bus.op_a  = 32'd5;
    bus.op_b  = 32'd3;
    sb.push_back(model(32'd5, 32'd3));
    sb.push_back(model(32'd100, 32'd7));
    @(posedge clk); #1;
    bus.op_a = 32'd100;
    bus.op_b = 32'd7;
    chk("t4_busy", 64'(bus.busy), 64'd1);
    wait_done(4, "t4_lat1");
    @(posedge clk); #1;
    chk("t4_ready", 64'(bus.ready), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t4_accept2", 64'(bus.busy), 64'd1);
    wait_done(8, "t4_lat2");
    @(posedge clk); #1;
    chk("t4_ready2", 64'(bus.ready), 64'd1);

    // Reset during the third S_RUN cycle discards the partial product.
    wait_ready();
    bus.start = 1'b1;
    bus.op_a  = 32'd9;
    bus.op_b  = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_product", 64'(bus.product), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_ready", 64'(bus.ready), 64'd1);
    seen_done = bus.done;
    repeat (15) begin
      @(posedge clk); #1;
      seen_done = seen_done | bus.done;
    end
    chk("t5_no_done", 64'(seen_done), 64'd0);
    run_mul(32'd3, 32'd4, "t5b", acc1);

    // Back-to-back: next start lands in the first idle cycle after done.
    run_mul(32'd6, 32'd6, "t6a", acc1);
    run_mul(32'd2, 32'd50, "t6b", acc2);
    chk("t6_throughput", 64'(acc2 - acc1), 64'd9);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time bound in case a wait loop is ever left unbounded.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequential multiplier built on repeated addition: product = op_a × op_b, mod 2^WIDTH.
- Contains the A, B and P registers, the adder, the B decrementer, the zero detector on B, and the FSM that sequences them.
- Sits beside the ALU as the multi-cycle MUL unit; the control unit starts it with a start/done handshake.

Parameters:
- WIDTH, 32, operand and product width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only while ready=1.
- op_a  input  WIDTH  multiplicand (addend); sampled together with start.
- op_b  input  WIDTH  multiplier (iteration count); sampled together with start.
- ready  output  1  high only in S_IDLE.
- busy  output  1  high in S_RUN and S_DONE.
- done  output  1  one-cycle pulse; product and ovf are valid.
- product  output  WIDTH  result; held until the next accepted start.
- ovf  output  1  sticky; set if any accumulation carried out of bit WIDTH-1.
- zero  output  1  high when product == 0; combinational from the product register.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state = S_IDLE; A, B, P = 0.
  - done = 0, ovf = 0, so product = 0, zero = 1, ready = 1, busy = 0.
  - Reset has priority over every other condition, including mid-S_RUN; the partial product is discarded.
- States, encoded S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2. Code 2'd3 is illegal and returns to S_IDLE on the next edge with no register updates.
- S_IDLE:
  - start=1: A ← op_a, B ← op_b, P ← 0, ovf ← 0, go to S_RUN.
  - start=0: hold all registers.
- S_RUN: beq = (B == 0), from an internal zero detector.
  - beq=0: P ← P + A, truncated to WIDTH bits. ovf ← ovf | carry-out. B ← B − 1. Stay in S_RUN.
  - beq=1: go to S_DONE; P, B and ovf hold.
- S_DONE: done = 1 for this single cycle; go to S_IDLE on the next edge.
- done is a registered output; it is high exactly while state = S_DONE.
- start is ignored whenever state ≠ S_IDLE. No queuing; the requester must wait for ready.
- Latency: let edge 0 be the edge that samples start.
  - done is high during the cycle after edge op_b+1.
  - ready returns after edge op_b+2.
  - op_b=0 gives done after edge 1 and product = 0.
- Arithmetic:
  - Unsigned only; the product is the low WIDTH bits of op_a × op_b.
  - op_a = 0 still iterates op_b times.
  - The decrement of B never wraps, because it occurs only when B ≠ 0.
- The operand inputs may change freely after the accept edge; the latched copies are used.
- The product register is not cleared at done; it holds the result and is overwritten with 0 only at the next accepted start.

Test Plan:
1. Reset, then start with op_a=7, op_b=5 → done high after edge 6 (one cycle only); product = 35; ovf = 0; zero = 0; ready high again after edge 7.
2. op_a=123, op_b=0 → done after edge 1; product = 0; zero = 1; ovf = 0. Also op_a=0, op_b=4 → done after edge 5; product = 0.
3. op_a=32'h8000_0000, op_b=3 → product = 32'h8000_0000; ovf = 1. Then op_a=2, op_b=2 → ovf cleared at accept; product = 4; ovf = 0.
4. Start held high continuously with op_a and op_b changed during S_RUN → only the first request executes; result uses the latched values; a second request is accepted on the first edge with ready=1.
5. Assert rst at the third S_RUN cycle of op_a=9, op_b=10 → next cycle product = 0, busy = 0, ready = 1, done never pulses; a following start with 3×4 gives 12.
6. Back-to-back: start reasserted in the first S_IDLE cycle after done → throughput of op_b+3 cycles per multiply; each done pulse matches its own operands (6×6=36, then 2×50=100).
